// File: rtl/isa_pkg.sv
// MIPS subset opcodes and the symbolic request encoding shared by the
// instruction encoder and the control decoder.
package isa_pkg;

  localparam logic [5:0] OP_ADD    = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] FUNCT_ADD = 6'h20;

  typedef enum logic [2:0] {
    InAdd     = 3'd0,
    InAddi    = 3'd1,
    InLw      = 3'd2,
    InSw      = 3'd3,
    InBeq     = 3'd4,
    InBne     = 3'd5,
    InJmp     = 3'd6,
    InInvalid = 3'd7
  } in_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } enc_state_e;

  function automatic logic [31:0] enc_itype(input logic [5:0]  opc,
                                            input logic [4:0]  rs,
                                            input logic [4:0]  rt,
                                            input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding {address, word} pairs; head reads as zero while empty.
module instr_fifo #(
  parameter int unsigned W     = 42,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (PW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic requests into MIPS words with sequential addresses and streams them out.
// Optional INSTR_ENC_BRANCH_CHECK_EN adds err_range and drops out-of-range branches.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [ADDR_W-1:0] in_target,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_word,
  output logic              done,
  output logic              err_unknown,
  output logic [ADDR_W:0]   count
`ifdef INSTR_ENC_BRANCH_CHECK_EN
  ,
  output logic              err_range
`endif
);

  localparam int unsigned OW = ADDR_W + 2;
  localparam int unsigned FW = ADDR_W + 32;

  enc_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W:0]   count_q;
  logic              err_unknown_q;

  logic              accept, push, pop, full, empty;
  logic              op_ok, is_branch, drop;
  logic [31:0]       word;
  logic signed [OW-1:0] off_full;
  logic [15:0]       off16;
  logic [FW-1:0]     head;
  in_op_e            op;

  assign op       = in_op_e'(in_op);
  assign in_ready = (state_q == StRun) && !full;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign out_valid = !empty;

  // Offset is relative to the word after the branch, in a width that cannot overflow.
  assign off_full = $signed({2'b00, in_target}) - $signed({2'b00, pc_q} + OW'(1));
  assign off16    = 16'(off_full);

  always_comb begin
    word      = '0;
    op_ok     = 1'b1;
    is_branch = 1'b0;
    case (op)
      InAdd:  word = {OP_ADD, in_rs, in_rt, in_rd, 5'b0, FUNCT_ADD};
      InAddi: word = enc_itype(OP_ADDI, in_rs, in_rt, in_imm);
      InLw:   word = enc_itype(OP_LW, in_rs, in_rt, in_imm);
      InSw:   word = enc_itype(OP_SW, in_rs, in_rt, in_imm);
      InBeq: begin
        word      = enc_itype(OP_BEQ, in_rs, in_rt, off16);
        is_branch = 1'b1;
      end
      InBne: begin
        word      = enc_itype(OP_BNE, in_rs, in_rt, off16);
        is_branch = 1'b1;
      end
      InJmp:  word = {OP_J, 26'(in_target)};
      default: op_ok = 1'b0;
    endcase
  end

`ifdef INSTR_ENC_BRANCH_CHECK_EN
  logic signed [OW-1:0] off_hi;
  logic                 range_bad;
  logic                 err_range_q;

  // In range iff every bit from 15 upward matches the sign.
  assign off_hi    = off_full >>> 15;
  assign range_bad = is_branch && !((off_hi == '0) || (off_hi == '1));
  assign drop      = !op_ok || range_bad;
  assign err_range = err_range_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_range_q <= 1'b0;
    end else if (start && state_q == StIdle) begin
      err_range_q <= 1'b0;
    end else if (accept && range_bad) begin
      err_range_q <= 1'b1;
    end
  end
`else
  assign drop = !op_ok;
`endif

  assign push = accept && !drop;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (accept && in_last) state_d = StDrain;
      end
      StDrain: begin
        if (empty) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      count_q       <= '0;
      err_unknown_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start && state_q == StIdle) begin
        pc_q          <= start_addr;
        count_q       <= '0;
        err_unknown_q <= 1'b0;
      end else begin
        if (push) pc_q <= pc_q + ADDR_W'(1);
        if (pop)  count_q <= count_q + (ADDR_W+1)'(1);
        if (accept && !op_ok) err_unknown_q <= 1'b1;
      end
    end
  end

  instr_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .wdata_i ({pc_q, word}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_addr    = head[FW-1:32];
  assign out_word    = head[31:0];
  assign count       = count_q;
  assign err_unknown = err_unknown_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed requests push expected {addr, word};
// a negedge monitor pops and compares on every output handshake.
module tb_instr_encoder;

`ifdef INSTR_ENC_BRANCH_CHECK_EN
  localparam int unsigned AW = 20;
`else
  localparam int unsigned AW = 10;
`endif

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready, in_last;
  logic [AW-1:0] start_addr, in_target, out_addr;
  logic [2:0]    in_op;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [15:0]   in_imm;
  logic          out_valid, out_ready, done, err_unknown;
  logic [31:0]   out_word;
  logic [AW:0]   count;
`ifdef INSTR_ENC_BRANCH_CHECK_EN
  logic          err_range;
`endif

  int tests = 0;
  int fails = 0;
  logic [AW+31:0] sb[$];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_word   (out_word),
    .done       (done),
    .err_unknown(err_unknown),
    .count      (count)
`ifdef INSTR_ENC_BRANCH_CHECK_EN
    ,
    .err_range  (err_range)
`endif
  );

  // Monitor: compares every transfer against the scoreboard and checks head stability.
  logic          hold_v = 1'b0;
  logic [AW-1:0] hold_a;
  logic [31:0]   hold_w;
  logic [AW+31:0] exp_e;

  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        tests++;
        if (out_valid !== 1'b1 || out_addr !== hold_a || out_word !== hold_w) begin
          fails++;
          $display("FAIL stable: got v=%0b addr=%h word=%h, want v=1 addr=%h word=%h",
                   out_valid, out_addr, out_word, hold_a, hold_w);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: got addr=%h word=%h, want nothing", out_addr, out_word);
        end else begin
          exp_e = sb.pop_front();
          if ({out_addr, out_word} !== exp_e) begin
            fails++;
            $display("FAIL out_word: got addr=%h word=%h, want addr=%h word=%h",
                     out_addr, out_word, exp_e[AW+31:32], exp_e[31:0]);
          end
        end
      end
      hold_v = out_valid && !out_ready;
      hold_a = out_addr;
      hold_w = out_word;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [AW-1:0] addr);
    start      = 1'b1;
    start_addr = addr;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [AW-1:0] tgt,
                      input logic last, input logic push_exp, input logic [AW-1:0] exp_addr,
                      input logic [31:0] exp_word);
    int n;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = tgt; in_last = last;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 after %0d cycles, want 1", n);
    end else begin
      if (push_exp) sb.push_back({exp_addr, exp_word});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_in_ready", in_ready, 0);
    @(posedge clk); #1;
  endtask

  localparam logic [AW-1:0] TOP = '1;

  initial begin
    reset = 1'b1; start = 1'b0; start_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_err_unknown", err_unknown, 0);
    check("rst_count", count, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_addr", out_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_ready", in_ready, 0);
    @(posedge clk); #1;

    // Mixed program starting at 0x010.
    do_start(AW'(12'h010));
    send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, '0, 1'b0, 1'b1, AW'(12'h010), 32'h00221820);
    send(3'd4, 5'd1, 5'd2, 5'd0, 16'h0, AW'(12'h010), 1'b0, 1'b1, AW'(12'h011), 32'h1022FFFE);
    send(3'd2, 5'd0, 5'd8, 5'd0, 16'h0004, '0, 1'b0, 1'b1, AW'(12'h012), 32'h8C080004);
    send(3'd1, 5'd3, 5'd4, 5'd0, 16'hFFFF, '0, 1'b0, 1'b1, AW'(12'h013), 32'h2064FFFF);
    send(3'd3, 5'd29, 5'd31, 5'd0, 16'h0010, '0, 1'b0, 1'b1, AW'(12'h014), 32'hAFBF0010);
    send(3'd5, 5'd5, 5'd6, 5'd0, 16'h0, AW'(12'h01A), 1'b0, 1'b1, AW'(12'h015), 32'h14A60004);
    send(3'd6, 5'd0, 5'd0, 5'd0, 16'h0, AW'(12'h040), 1'b1, 1'b1, AW'(12'h016), 32'h08000040);
    wait_done();
    check("seq_count", count, 7);

    // Backpressure: four fill the FIFO, the fifth waits for the first pop.
    out_ready = 1'b0;
    do_start(AW'(12'h020));
    send(3'd0, 5'd1, 5'd2, 5'd4, 16'h0, '0, 1'b0, 1'b1, AW'(12'h020), 32'h00222020);
    send(3'd0, 5'd1, 5'd2, 5'd5, 16'h0, '0, 1'b0, 1'b1, AW'(12'h021), 32'h00222820);
    send(3'd0, 5'd1, 5'd2, 5'd6, 16'h0, '0, 1'b0, 1'b1, AW'(12'h022), 32'h00223020);
    send(3'd0, 5'd1, 5'd2, 5'd7, 16'h0, '0, 1'b0, 1'b1, AW'(12'h023), 32'h00223820);
    fork
      send(3'd0, 5'd1, 5'd2, 5'd8, 16'h0, '0, 1'b1, 1'b1, AW'(12'h024), 32'h00224020);
      begin
        repeat (3) @(negedge clk);
        check("bp_full_ready", in_ready, 0);
        check("bp_head_addr", out_addr, 64'h020);
        check("bp_head_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_done();
    check("bp_count", count, 5);

    // Invalid op inside a program: pc does not advance.
    do_start(AW'(12'h100));
    send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, '0, 1'b0, 1'b1, AW'(12'h100), 32'h00221820);
    send(3'd7, 5'd1, 5'd2, 5'd3, 16'h0, '0, 1'b0, 1'b0, '0, 32'h0);
    @(negedge clk);
    check("inv_err_set", err_unknown, 1);
    @(posedge clk); #1;
    send(3'd0, 5'd1, 5'd2, 5'd4, 16'h0, '0, 1'b1, 1'b1, AW'(12'h101), 32'h00222020);
    wait_done();
    check("inv_count", count, 2);

    // Invalid op as the last request of a program.
    do_start(AW'(12'h200));
    @(negedge clk);
    check("start_clears_err", err_unknown, 0);
    @(posedge clk); #1;
    send(3'd7, 5'd0, 5'd0, 5'd0, 16'h0, '0, 1'b1, 1'b0, '0, 32'h0);
    wait_done();
    check("inv_last_valid", out_valid, 0);
    check("inv_last_err", err_unknown, 1);
    check("inv_last_count", count, 0);

    // Address wrap.
    do_start(TOP);
    send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, '0, 1'b0, 1'b1, TOP, 32'h00221820);
    send(3'd0, 5'd1, 5'd2, 5'd4, 16'h0, '0, 1'b1, 1'b1, '0, 32'h00222020);
    wait_done();
    check("wrap_count", count, 2);

`ifdef INSTR_ENC_BRANCH_CHECK_EN
    // Out-of-range branch is dropped; the following in-range one keeps address 0.
    do_start('0);
    send(3'd4, 5'd1, 5'd2, 5'd0, 16'h0, AW'(20'h10000), 1'b0, 1'b0, '0, 32'h0);
    @(negedge clk);
    check("range_err", err_range, 1);
    check("range_no_out", out_valid, 0);
    @(posedge clk); #1;
    send(3'd4, 5'd1, 5'd2, 5'd0, 16'h0, AW'(20'h08000), 1'b1, 1'b1, '0, 32'h10227FFF);
    wait_done();
    check("range_count", count, 1);
`endif

    // Mid-stream reset with three words queued.
    do_start('0);
    send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, '0, 1'b0, 1'b1, '0, 32'h00221820);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'd0, 5'd1, 5'd2, 5'd4, 16'h0, '0, 1'b0, 1'b0, '0, 32'h0);
    send(3'd0, 5'd1, 5'd2, 5'd5, 16'h0, '0, 1'b0, 1'b0, '0, 32'h0);
    send(3'd0, 5'd1, 5'd2, 5'd6, 16'h0, '0, 1'b0, 1'b0, '0, 32'h0);
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_count", count, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_word", out_word, 0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the control decoder: turns symbolic instruction requests (mnemonic code plus register and immediate fields) into 32-bit MIPS words for the supported subset (ADD, ADDI, LW, SW, BEQ, BNE, JMP).
- Assigns each word a sequential instruction-memory address and buffers it in a small FIFO.
- Emits word and address over a valid/ready stream to the instruction-memory loader; the decoder later reads these words back.

Parameters:
- ADDR_W, 10, width of the word address / program counter.
- DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse. Loads pc from start_addr, clears errors, enters RUN.
- start_addr  in  ADDR_W  first word address.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  3  0 ADD, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 JMP, 7 invalid.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate / load-store offset.
- in_target  in  ADDR_W  absolute word address for BEQ/BNE/JMP.
- in_last  in  1  marks the final request of a program.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_addr  out  ADDR_W  word address of head.
- out_word  out  32  encoded instruction.
- done  out  1  one-cycle pulse when the program is fully drained.
- err_unknown  out  1  sticky: an in_op==7 request was seen.
- count  out  ADDR_W+1  words emitted since start.

Behaviour:
- Reset values:
  - in_ready=0, out_valid=0, done=0, err_unknown=0, count=0, pc=0.
  - FIFO empty, state IDLE.
  - out_word and out_addr are 0 while empty.
- States:
  - IDLE: in_ready=0. start moves to RUN.
  - RUN: in_ready = FIFO not full. No bypass, so a full FIFO holds in_ready low even when out_ready=1. An accepted request with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty, done=1 for one cycle and the block returns to IDLE.
  - start in RUN or DRAIN is ignored.
- Encoding (registered, pushed the cycle after acceptance):
  - ADD = {6'h00, rs, rt, rd, 5'b0, 6'h20}.
  - ADDI = {6'h08, rs, rt, imm}.
  - LW = {6'h23, rs, rt, imm}.
  - SW = {6'h2B, rs, rt, imm}.
  - BEQ = {6'h04, rs, rt, off}.
  - BNE = {6'h05, rs, rt, off}.
  - JMP = {6'h02, target zero-extended to 26}.
- Branch offset:
  - off = target - (pc+1), computed signed in ADDR_W+2 bits.
  - The result is sign-extended or truncated to 16 bits.
- Latency: a request accepted at cycle N appears at the FIFO head (out_valid=1) at N+1 at the earliest.
- pc handling:
  - pc increments by 1 per encoded word and wraps modulo 2^ADDR_W silently.
  - out_addr is the pc value at acceptance.
- Invalid op (7): the handshake completes, but the request is not pushed, pc is not incremented and err_unknown is set. If in_last=1 it still moves to DRAIN.
- Output stream:
  - Pop occurs when out_valid && out_ready; count increments on each pop.
  - Push and pop in the same cycle are both allowed.
  - out_word and out_addr must stay stable while out_valid && !out_ready.
- Reset mid-operation: FIFO flushed and all outputs return to reset values on the next edge.

Optional Feature:
- Macro: INSTR_ENC_BRANCH_CHECK_EN.
- When defined:
  - Adds output port err_range (1, sticky, cleared by start).
  - A BEQ/BNE whose off falls outside -32768..32767 is dropped like an invalid op, and err_range is set.
- When undefined: the port is absent and off is truncated to 16 bits without indication.

Decomposition:
- Shared package (isa_pkg):
  - Opcode constants OP_ADD=6'h00, OP_ADDI=6'h08, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_BNE=6'h05, OP_J=6'h02, and FUNCT_ADD=6'h20.
  - The 3-bit in_op enumeration.
  - These are reused by the control decoder.
- One natural sub-module: instr_fifo, a synchronous FIFO {ADDR_W+32}xDEPTH with full/empty flags.

Test Plan:
- Encode sequence: start_addr=0x010; ADD rs=1 rt=2 rd=3 -> out_addr 0x010, out_word 0x00221820.
- Branch, load and jump:
  - BEQ rs=1 rt=2 target=0x010 at pc 0x011 -> 0x1022FFFE.
  - LW rt=8 imm=4 -> 0x8C080004.
  - JMP target=0x040 -> 0x08000040.
- Backpressure: out_ready=0, five valid requests -> four accepted, in_ready=0 after the fourth; out_ready=1 -> words drain in order with stable data, fifth accepted.
- Invalid op and drain: in_op=7 with in_last=1 -> err_unknown=1, no out_valid, pc unchanged; done pulses once, state IDLE.
- Wrap and count: ADDR_W=10, start_addr=0x3FF, two ADDs -> addresses 0x3FF then 0x000, count=2.
- Mid-stream reset: reset with 3 words queued -> out_valid=0, count=0, in_ready=0 the next cycle.
- Range check (macro on, ADDR_W=20): BEQ pc=0, target=0x10000 -> err_range=1, nothing emitted.
